scan_chain_ctrl: RTL and testbench



---
 rtl/scan_pkg.sv | 27 ++
 rtl/scan_lane.sv | 52 +++++
 rtl/scan_chain_ctrl.sv | 177 +++++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the multi-chain scan controller.
// Holds the FSM state encoding, the mode encodings and the index-width helper.
package scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN_LOW,
    ST_SCAN_HIGH,
    ST_PUSH,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_CAPTURE = 2'b00;
  localparam logic [1:0] MODE_RESTORE = 2'b01;
  localparam logic [1:0] MODE_SWAP    = 2'b10;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/scan_lane.sv
// One scan chain lane: a shift-in word driven onto the chain and a shift-out
// word collected from it, both addressed by the controller's shared bit index.
module scan_lane
  import scan_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = clog2(DATA_W)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_data,
  input  logic              sample_en,
  input  logic              scan_out_bit,
  input  logic [IDX_W-1:0]  bit_idx,
  input  logic              drive_en,
  output logic              scan_in_bit,
  output logic [DATA_W-1:0] shift_out
);

  logic [DATA_W-1:0] shift_in_q, shift_in_d;
  logic [DATA_W-1:0] shift_out_q, shift_out_d;

  // Sampling bit 0 marks the start of a new word, so stale bits are dropped.
  always_comb begin
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    if (load_en) begin
      shift_in_d = load_data;
    end
    if (sample_en) begin
      if (bit_idx == '0) begin
        shift_out_d = '0;
      end
      shift_out_d[bit_idx] = scan_out_bit;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      shift_in_q  <= '0;
      shift_out_q <= '0;
    end else begin
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
    end
  end

  assign scan_in_bit = drive_en & shift_in_q[bit_idx];
  assign shift_out   = shift_out_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Multi-chain scan controller: drives NUM_CHAINS chains in lock-step for
// capture, restore or swap passes between the host FIFOs and the DUT.
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_CHAINS = 4,
  parameter int LEN_W      = 16
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [1:0]                   mode,
  input  logic [LEN_W-1:0]             length,
  output logic                         busy,
  output logic                         done,
  output logic                         scan_enable,
  output logic                         scan_ck_enable,
  output logic [NUM_CHAINS-1:0]        scan_in,
  input  logic [NUM_CHAINS-1:0]        scan_out,
  input  logic [NUM_CHAINS*DATA_W-1:0] in_data,
  input  logic                         in_empty,
  output logic                         in_rd_en,
  output logic [NUM_CHAINS*DATA_W-1:0] out_data,
  input  logic                         out_full,
  output logic                         out_wr_en
);

  localparam int IDX_W = clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t                       state_q, state_d;
  logic [1:0]                   mode_q, mode_d, start_mode;
  logic [LEN_W-1:0]             len_q, len_d;
  logic [LEN_W-1:0]             total_q, total_d;
  logic [IDX_W-1:0]             bit_idx_q, bit_idx_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         scan_enable_q, scan_enable_d;
  logic                         scan_ck_enable_q, scan_ck_enable_d;
  logic                         in_rd_en_q, in_rd_en_d;
  logic                         out_wr_en_q, out_wr_en_d;
  logic [NUM_CHAINS*DATA_W-1:0] out_data_q, out_data_d;
  logic [NUM_CHAINS*DATA_W-1:0] shift_out_all;
  logic                         load_en, sample_en, drive_en;
  logic                         last_bit, word_end;

  assign start_mode = (mode == MODE_RESTORE || mode == MODE_SWAP) ? mode : MODE_CAPTURE;
  assign last_bit   = (total_q + LEN_W'(1)) == len_q;
  assign word_end   = bit_idx_q == LAST_IDX;
  assign drive_en   = scan_enable_q && (mode_q != MODE_CAPTURE);

  // Abort wins over every other transition and suppresses any new FIFO access.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    total_d     = total_q;
    bit_idx_d   = bit_idx_q;
    in_rd_en_d  = 1'b0;
    out_wr_en_d = 1'b0;
    out_data_d  = out_data_q;
    load_en     = 1'b0;
    sample_en   = 1'b0;
    if (state_q != ST_IDLE && abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_d    = start_mode;
            len_d     = length;
            total_d   = '0;
            bit_idx_d = '0;
            if (length == '0)                    state_d = ST_DONE;
            else if (start_mode != MODE_CAPTURE) state_d = ST_LOAD;
            else                                 state_d = ST_SCAN_LOW;
          end
        end
        ST_LOAD: begin
          if (!in_empty) begin
            load_en    = 1'b1;
            in_rd_en_d = 1'b1;
            state_d    = ST_SCAN_LOW;
          end
        end
        ST_SCAN_LOW: begin
          sample_en = 1'b1;
          state_d   = ST_SCAN_HIGH;
        end
        ST_SCAN_HIGH: begin
          bit_idx_d = bit_idx_q + IDX_W'(1);
          total_d   = total_q + LEN_W'(1);
          if (last_bit || word_end) begin
            if (mode_q == MODE_RESTORE) state_d = last_bit ? ST_DONE : ST_LOAD;
            else                        state_d = ST_PUSH;
          end else begin
            state_d = ST_SCAN_LOW;
          end
        end
        ST_PUSH: begin
          if (!out_full) begin
            out_wr_en_d = 1'b1;
            out_data_d  = shift_out_all;
            if (total_q == len_q)         state_d = ST_DONE;
            else if (mode_q == MODE_SWAP) state_d = ST_LOAD;
            else                          state_d = ST_SCAN_LOW;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d           = state_d != ST_IDLE;
    done_d           = state_d == ST_DONE;
    scan_enable_d    = (state_d == ST_SCAN_LOW) || (state_d == ST_SCAN_HIGH);
    scan_ck_enable_d = state_d == ST_SCAN_HIGH;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q          <= ST_IDLE;
      mode_q           <= MODE_CAPTURE;
      len_q            <= '0;
      total_q          <= '0;
      bit_idx_q        <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      scan_enable_q    <= 1'b0;
      scan_ck_enable_q <= 1'b0;
      in_rd_en_q       <= 1'b0;
      out_wr_en_q      <= 1'b0;
      out_data_q       <= '0;
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      len_q            <= len_d;
      total_q          <= total_d;
      bit_idx_q        <= bit_idx_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      scan_enable_q    <= scan_enable_d;
      scan_ck_enable_q <= scan_ck_enable_d;
      in_rd_en_q       <= in_rd_en_d;
      out_wr_en_q      <= out_wr_en_d;
      out_data_q       <= out_data_d;
    end
  end

  for (genvar i = 0; i < NUM_CHAINS; i++) begin : g_lane
    scan_lane #(
      .DATA_W(DATA_W),
      .IDX_W (IDX_W)
    ) u_lane (
      .aclk        (aclk),
      .areset      (areset),
      .load_en     (load_en),
      .load_data   (in_data[i*DATA_W +: DATA_W]),
      .sample_en   (sample_en),
      .scan_out_bit(scan_out[i]),
      .bit_idx     (bit_idx_q),
      .drive_en    (drive_en),
      .scan_in_bit (scan_in[i]),
      .shift_out   (shift_out_all[i*DATA_W +: DATA_W])
    );
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign scan_enable    = scan_enable_q;
  assign scan_ck_enable = scan_ck_enable_q;
  assign in_rd_en       = in_rd_en_q;
  assign out_wr_en      = out_wr_en_q;
  assign out_data       = out_data_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with DATA_W=8, NUM_CHAINS=2, modelling
// two 16-bit DUT chains plus the input and output FIFOs around the controller.
module tb_scan_chain_ctrl;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] length = 16'd0;
  logic        busy, done, scan_enable, scan_ck_enable;
  logic [1:0]  scan_in, scan_out;
  logic [15:0] in_data;
  logic        in_empty;
  logic        in_rd_en;
  logic [15:0] out_data;
  logic        out_full = 1'b0;
  logic        out_wr_en;

  logic        stall_in = 1'b0;
  int          cfg_gen = 0;
  logic [15:0] pre0 = 16'h0, pre1 = 16'h0;
  logic [15:0] cfg_words [4];
  int          cfg_nwords = 0;

  logic [15:0] chain0, chain1;
  logic [15:0] out_words [8];
  int          out_cnt, rd_ptr, ck_count, ck_b2b, done_count, se_count, seen_gen;
  logic        prev_ck;

  int n_checks = 0;
  int n_fail   = 0;

  scan_chain_ctrl #(.DATA_W(8), .NUM_CHAINS(2), .LEN_W(16)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .start         (start),
    .abort         (abort),
    .mode          (mode),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .scan_enable   (scan_enable),
    .scan_ck_enable(scan_ck_enable),
    .scan_in       (scan_in),
    .scan_out      (scan_out),
    .in_data       (in_data),
    .in_empty      (in_empty),
    .in_rd_en      (in_rd_en),
    .out_data      (out_data),
    .out_full      (out_full),
    .out_wr_en     (out_wr_en)
  );

  always #5 aclk = ~aclk;

  assign scan_out = {chain1[0], chain0[0]};
  assign in_empty = stall_in || (rd_ptr >= cfg_nwords);
  assign in_data  = (rd_ptr < cfg_nwords && rd_ptr < 4) ? cfg_words[rd_ptr[1:0]] : 16'h0;

  // Environment: chains shift during the scan-clock cycle, FIFOs pop/push once per strobe.
  always @(negedge aclk) begin
    if (cfg_gen != seen_gen) begin
      seen_gen   <= cfg_gen;
      chain0     <= pre0;
      chain1     <= pre1;
      rd_ptr     <= 0;
      out_cnt    <= 0;
      ck_count   <= 0;
      ck_b2b     <= 0;
      done_count <= 0;
      se_count   <= 0;
      prev_ck    <= 1'b0;
    end else begin
      if (scan_ck_enable) begin
        ck_count <= ck_count + 1;
        if (prev_ck) ck_b2b <= ck_b2b + 1;
        chain0 <= {scan_in[0], chain0[15:1]};
        chain1 <= {scan_in[1], chain1[15:1]};
      end
      prev_ck <= scan_ck_enable;
      if (done)        done_count <= done_count + 1;
      if (scan_enable) se_count <= se_count + 1;
      if (in_rd_en)    rd_ptr <= rd_ptr + 1;
      if (out_wr_en) begin
        if (out_cnt < 8) out_words[out_cnt[2:0]] <= out_data;
        out_cnt <= out_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(negedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic configure(input logic [15:0] c0, input logic [15:0] c1,
                           input logic [15:0] w0, input logic [15:0] w1, input int nw);
    pre0 = c0;
    pre1 = c1;
    cfg_words[0] = w0;
    cfg_words[1] = w1;
    cfg_words[2] = 16'h0;
    cfg_words[3] = 16'h0;
    cfg_nwords = nw;
    cfg_gen++;
    tick();
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [15:0] len);
    mode   = m;
    length = len;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    checkOutput({tag, "_idle"}, 32'(busy), 32'h0);
  endtask

  task automatic wait_ck(input int target, input string tag);
    int n = 0;
    while (ck_count < target && n < 400) begin
      tick();
      n++;
    end
    checkOutput({tag, "_ck_reached"}, ck_count, target);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    tick();
    tick();
    checkOutput("rst_ctrl", 32'({busy, done, scan_enable, scan_ck_enable, scan_in, in_rd_en, out_wr_en}), 32'h0);
    checkOutput("rst_out_data", 32'(out_data), 32'h0);
    areset = 1'b0;
    tick();

    // Capture, length 12
    configure(16'h0123, 16'h0ABC, 16'h0, 16'h0, 0);
    applyStimulus(2'b00, 16'd12);
    checkOutput("cap_c1_se", 32'(scan_enable), 32'h1);
    checkOutput("cap_c1_ck", 32'(scan_ck_enable), 32'h0);
    tick();
    checkOutput("cap_c2_ck", 32'(scan_ck_enable), 32'h1);
    checkOutput("cap_c2_scan_in", 32'(scan_in), 32'h0);
    wait_idle("cap");
    checkOutput("cap_pushes", out_cnt, 2);
    checkOutput("cap_word0", 32'(out_words[0]), 32'hBC23);
    checkOutput("cap_word1", 32'(out_words[1]), 32'h0A01);
    checkOutput("cap_done", done_count, 1);
    checkOutput("cap_ck_count", ck_count, 12);
    checkOutput("cap_ck_b2b", ck_b2b, 0);
    checkOutput("cap_no_rd", rd_ptr, 0);
    checkOutput("cap_chain0_zero_fill", 32'(chain0), 32'h0);

    // Reserved mode behaves as capture
    configure(16'h0005, 16'h0006, 16'h0, 16'h0, 0);
    applyStimulus(2'b11, 16'd3);
    wait_idle("rsv");
    checkOutput("rsv_pushes", out_cnt, 1);
    checkOutput("rsv_word0", 32'(out_words[0]), 32'h0605);
    checkOutput("rsv_no_rd", rd_ptr, 0);

    // Restore, length 16
    configure(16'hFFFF, 16'hFFFF, 16'h5AA5, 16'hC33C, 2);
    applyStimulus(2'b01, 16'd16);
    checkOutput("rst_c1_ck", 32'(scan_ck_enable), 32'h0);
    tick();
    checkOutput("res_c2_ck", 32'(scan_ck_enable), 32'h0);
    tick();
    checkOutput("res_c3_ck", 32'(scan_ck_enable), 32'h1);
    wait_idle("res");
    checkOutput("res_rd_count", rd_ptr, 2);
    checkOutput("res_no_wr", out_cnt, 0);
    checkOutput("res_chain0", 32'(chain0), 32'h3CA5);
    checkOutput("res_chain1", 32'(chain1), 32'hC35A);
    checkOutput("res_done", done_count, 1);
    checkOutput("res_ck_b2b", ck_b2b, 0);

    // Swap with FIFO stalls
    configure(16'h1357, 16'h9BDF, 16'h1234, 16'hABCD, 2);
    stall_in = 1'b1;
    out_full = 1'b1;
    applyStimulus(2'b10, 16'd16);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("swp_load_stall_ck", ck_count, 0);
    checkOutput("swp_load_stall_rd", rd_ptr, 0);
    checkOutput("swp_load_busy", 32'(busy), 32'h1);
    stall_in = 1'b0;
    wait_ck(8, "swp");
    for (int i = 0; i < 4; i++) tick();
    checkOutput("swp_push_stall_ck", ck_count, 8);
    checkOutput("swp_push_stall_wr", out_cnt, 0);
    out_full = 1'b0;
    wait_idle("swp");
    checkOutput("swp_pushes", out_cnt, 2);
    checkOutput("swp_word0", 32'(out_words[0]), 32'hDF57);
    checkOutput("swp_word1", 32'(out_words[1]), 32'h9B13);
    checkOutput("swp_chain0", 32'(chain0), 32'hCD34);
    checkOutput("swp_chain1", 32'(chain1), 32'hAB12);
    checkOutput("swp_rd_count", rd_ptr, 2);
    checkOutput("swp_done", done_count, 1);

    // Zero length
    configure(16'h1111, 16'h2222, 16'h0, 16'h0, 0);
    applyStimulus(2'b01, 16'd0);
    tick();
    tick();
    checkOutput("len0_done", done_count, 1);
    checkOutput("len0_se", se_count, 0);
    checkOutput("len0_no_fifo", rd_ptr + out_cnt, 0);
    checkOutput("len0_idle", 32'(busy), 32'h0);

    // Abort during SCAN_HIGH of bit 5
    configure(16'h0123, 16'h0ABC, 16'h0, 16'h0, 0);
    applyStimulus(2'b00, 16'd12);
    wait_ck(6, "abt");
    checkOutput("abt_in_high", 32'(scan_ck_enable), 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abt_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("abt_done", done_count, 0);
    checkOutput("abt_no_wr", out_cnt, 0);

    // Reset mid-pass, then a fresh capture
    configure(16'h0123, 16'h0ABC, 16'h0, 16'h0, 0);
    applyStimulus(2'b00, 16'd12);
    wait_ck(3, "mid");
    areset = 1'b1;
    tick();
    checkOutput("mid_rst_ctrl", 32'({busy, done, scan_enable, scan_ck_enable, scan_in, in_rd_en, out_wr_en}), 32'h0);
    checkOutput("mid_rst_out_data", 32'(out_data), 32'h0);
    areset = 1'b0;
    tick();
    configure(16'h00F1, 16'h0F0E, 16'h0, 16'h0, 0);
    applyStimulus(2'b00, 16'd8);
    wait_idle("post");
    checkOutput("post_pushes", out_cnt, 1);
    checkOutput("post_word0", 32'(out_words[0]), 32'h0EF1);
    checkOutput("post_ck_count", ck_count, 8);
    checkOutput("post_done", done_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
